sevseg_scan_ctrl: RTL and testbench
===================================

SEVSEG_SCAN_CTRL -- requirements
Module: sevseg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits (legal range 1..16).
REQ-002 Parameter PHASE_LEN, default 625, clk cycles per brightness phase (legal range 1 or more); a digit slot is 8*PHASE_LEN cycles.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 Rst  in  1  synchronous active-high reset.
REQ-006 data  in  4*NUM_DIGITS  hex nibbles; digit k is data[4k+3:4k].
REQ-007 digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit.
REQ-008 dp_in  in  NUM_DIGITS  per-digit decimal point request, active high.
REQ-009 bright  in  3  brightness level 0..7.
REQ-010 an  out  NUM_DIGITS  anode selects, active low, at most one bit low.
REQ-011 sev_out  out  7  segments a..g on bits 6..0, active low.
REQ-012 dp_out  out  1  decimal point, active low.
REQ-013 frame_start  out  1  one-cycle pulse at the start of each digit-0 slot.

Function
REQ-014 The phase counter SHALL count 0..PHASE_LEN-1 and wrap; each wrap SHALL advance phase 0..7; a phase-7 wrap SHALL advance digit index 0..NUM_DIGITS-1, wrapping to 0.
REQ-015 When the digit index wraps to 0, data, digit_en and dp_in SHALL be snapshotted in the same cycle; no input change SHALL alter a frame already in progress.
REQ-016 frame_start SHALL be 1 for exactly the cycle in which the registered outputs first show the digit-0 slot.
REQ-017 All outputs SHALL be registered, with one cycle of latency from the counter state they reflect.
REQ-018 During slot k, an[k] SHALL be 0 only when the current phase is less than or equal to the snapshotted bright; otherwise an SHALL be all ones. bright=7 gives full duty; bright=0 gives 1/8 duty.
REQ-019 bright SHALL be sampled at every phase boundary, not snapshotted per frame.
REQ-020 A disabled or blanked digit SHALL drive an all ones, sev_out 7'h7F and dp_out 1 for its whole slot.
REQ-021 Hex decode, active low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-022 dp_out SHALL be ~dp_snap[k] while an[k] is low, and 1 otherwise.

Reset
REQ-023 While Rst=1: an all ones, sev_out 7'h7F, dp_out 1, frame_start 0, all counters 0, all snapshots 0.
REQ-024 On the first cycle after Rst falls, the snapshot SHALL load and the first slot SHALL be digit 0, with frame_start asserted one cycle later.
REQ-025 Asserting Rst mid-slot or mid-frame SHALL abort the frame immediately, with no partial digit held.

Configuration
REQ-026 Macro SEVSEG_LZB_EN: when defined, the block SHALL blank leading zeros. At the snapshot, digits from NUM_DIGITS-1 downward whose nibble is 0 are blanked until the first nonzero nibble or the first digit with dp set; digit 0 is never blanked. When the macro is undefined, no leading-zero blanking logic SHALL exist and zero digits SHALL display "0".

Structure
REQ-027 Package sevseg_pkg SHALL hold the 16-entry segment table, the SEG_BLANK constant (7'h7F) and the phase-count constant 8.
REQ-028 Sub-module sevseg_decoder SHALL be the single combinational nibble-to-segment decoder, instantiated once on the muxed nibble.
REQ-029 The counters and snapshot registers SHALL live in sevseg_scan_ctrl; nothing SHALL be generated per digit except the snapshot bits.

Verification
REQ-030 NUM_DIGITS=8, PHASE_LEN=4, bright=7, data=32'h12345678, all enabled: an SHALL cycle FE, FD, ... 7F every 32 cycles, and sev_out SHALL be 8's code, then 7's, and so on.
REQ-031 bright=2, PHASE_LEN=4: each slot SHALL hold an low for 12 cycles, then all ones for 20 cycles.
REQ-032 data changes to 32'hFFFFFFFF mid-frame: the remaining slots SHALL still show the old nibbles, and the new nibbles SHALL appear only after the next frame_start.
REQ-033 With SEVSEG_LZB_EN, data=32'h00000A05: digits 7..3 blank and digits 2..0 show A,0,5; with dp_in[5]=1, digit 5 SHALL show 0 with dp lit.
REQ-034 Rst pulsed at slot 5, phase 3: the next cycle SHALL show all reset values, and the following frame SHALL restart at digit 0.
REQ-035 digit_en=8'h0F: slots 4..7 SHALL keep an=FF and sev_out=7F while the cadence is unchanged.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scan controller: segment table,
// blank pattern and brightness phase count.
package sevseg_pkg;

  localparam int unsigned NUM_PHASES = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low a..g on bits 6..0; entry n is the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

endpackage

// File: rtl/sevseg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sevseg_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with per-frame input snapshot and PWM brightness.
// Define SEVSEG_LZB_EN to enable leading-zero blanking.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PHASE_LEN  = 625
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [2:0]              bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sev_out,
  output logic                    dp_out,
  output logic                    frame_start
);

  localparam int unsigned CNT_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PHASE_LEN - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [2:0]       PHASE_LAST = 3'(NUM_PHASES - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              phase_q, phase_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic                    load_pend_q;
  logic [2:0]              bright_q;
  logic [4*NUM_DIGITS-1:0] data_snap_q;
  logic [NUM_DIGITS-1:0]   en_snap_q, dp_snap_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              sev_q, sev_d;
  logic                    dp_q, dp_d, fs_q, fs_d;

  logic       cnt_wrap, frame_wrap, snap_load, show, lit;
  logic [3:0] nib;
  logic [6:0] seg;

  assign cnt_wrap   = (cnt_q == CNT_LAST);
  assign frame_wrap = cnt_wrap && (phase_q == PHASE_LAST) && (digit_q == DIG_LAST);
  // The first cycle out of reset only loads the snapshot; counters start after it.
  assign snap_load  = load_pend_q || frame_wrap;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    digit_d = digit_q;
    if (!load_pend_q) begin
      if (cnt_wrap) begin
        cnt_d   = '0;
        phase_d = phase_q + 3'd1;
        if (phase_q == PHASE_LAST) begin
          digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
        end else begin
          digit_d = digit_q;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_q       <= '0;
      phase_q     <= 3'd0;
      digit_q     <= '0;
      load_pend_q <= 1'b1;
      bright_q    <= 3'd0;
      data_snap_q <= '0;
      en_snap_q   <= '0;
      dp_snap_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      digit_q     <= digit_d;
      load_pend_q <= 1'b0;
      if (cnt_wrap || load_pend_q) begin
        bright_q <= bright;
      end
      if (snap_load) begin
        data_snap_q <= data;
        en_snap_q   <= digit_en;
        dp_snap_q   <= dp_in;
      end
    end
  end

`ifdef SEVSEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask, blank_snap_q;

  // Blank zeros from the top digit down until a nonzero nibble or a lit dp.
  always_comb begin
    logic leading;
    leading  = 1'b1;
    lzb_mask = '0;
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      if (leading && (data[4*k +: 4] == 4'h0) && !dp_in[k]) begin
        lzb_mask[k] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      blank_snap_q <= '0;
    end else if (snap_load) begin
      blank_snap_q <= lzb_mask;
    end
  end

  assign show = en_snap_q[digit_q] && !blank_snap_q[digit_q];
`else
  assign show = en_snap_q[digit_q];
`endif

  assign nib = data_snap_q[{digit_q, 2'b00} +: 4];

  sevseg_decoder u_dec (
    .nibble_i (nib),
    .seg_o    (seg)
  );

  assign lit = !load_pend_q && show && (phase_q <= bright_q);

  always_comb begin
    an_d  = lit ? ~(NUM_DIGITS'(1) << digit_q) : '1;
    sev_d = lit ? seg : SEG_BLANK;
    dp_d  = lit ? ~dp_snap_q[digit_q] : 1'b1;
    fs_d  = !load_pend_q && (cnt_q == '0) && (phase_q == 3'd0) && (digit_q == '0);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      an_q  <= '1;
      sev_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      an_q  <= an_d;
      sev_q <= sev_d;
      dp_q  <= dp_d;
      fs_q  <= fs_d;
    end
  end

  assign an          = an_q;
  assign sev_out     = sev_q;
  assign dp_out      = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl with NUM_DIGITS=8, PHASE_LEN=4 (32-cycle slots).
module tb_sevseg_scan_ctrl;

  localparam int ND = 8;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          Rst;
  logic [31:0]   data;
  logic [7:0]    digit_en, dp_in;
  logic [2:0]    bright;
  logic [7:0]    an;
  logic [6:0]    sev_out;
  logic          dp_out, frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  always #5 clk = ~clk;

  sevseg_scan_ctrl #(.NUM_DIGITS(ND), .PHASE_LEN(PL)) dut (
    .clk         (clk),
    .Rst         (Rst),
    .data        (data),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .bright      (bright),
    .an          (an),
    .sev_out     (sev_out),
    .dp_out      (dp_out),
    .frame_start (frame_start)
  );

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'b0000001;
      4'h1: hex_seg = 7'b1001111;
      4'h2: hex_seg = 7'b0010010;
      4'h3: hex_seg = 7'b0000110;
      4'h4: hex_seg = 7'b1001100;
      4'h5: hex_seg = 7'b0100100;
      4'h6: hex_seg = 7'b0100000;
      4'h7: hex_seg = 7'b0001111;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0000100;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b1100000;
      4'hC: hex_seg = 7'b0110001;
      4'hD: hex_seg = 7'b1000010;
      4'hE: hex_seg = 7'b0110000;
      default: hex_seg = 7'b0111000;
    endcase
  endfunction

  function automatic logic [7:0] an_sel(input int k);
    an_sel = 8'hFF ^ (8'h01 << k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t = t + 1;
  endtask

  task automatic adv_to(input int target);
    while (t < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at t=%0d: observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  initial begin
    int lows;
    int bad;
    Rst      = 1'b1;
    data     = 32'h12345678;
    digit_en = 8'hFF;
    dp_in    = 8'h00;
    bright   = 3'd7;
    repeat (3) tick();
    chk("rst_an", an, 8'hFF);
    chk("rst_sev", sev_out, 7'h7F);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_fs", frame_start, 1'b0);

    // Release: one snapshot cycle, then digit 0 with frame_start.
    Rst = 1'b0;
    tick();
    chk("rel_an", an, 8'hFF);
    chk("rel_fs", frame_start, 1'b0);
    tick();
    t = 0;
    chk("f0_fs", frame_start, 1'b1);
    chk("f0_an", an, 8'hFE);
    chk("f0_sev", sev_out, hex_seg(4'h8));
    chk("f0_dp", dp_out, 1'b1);
    tick();
    chk("f0_fs_pulse", frame_start, 1'b0);

    // Full-brightness scan across all eight digits.
    for (int k = 1; k < 8; k++) begin
      adv_to(32 * k - 1);
      chk("slot_end_an", an, an_sel(k - 1));
      tick();
      chk("slot_an", an, an_sel(k));
      chk("slot_sev", sev_out, hex_seg(4'(8 - k)));
      chk("slot_fs", frame_start, 1'b0);
    end
    adv_to(256);
    chk("f1_fs", frame_start, 1'b1);
    chk("f1_an", an, 8'hFE);

    // bright=2: 12 lit cycles then 20 dark in slot 0.
    bright = 3'd2;
    lows = 0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      if (an == 8'hFE) lows++;
      if (i == 11) chk("b2_last_lit", an, 8'hFE);
      if (i == 12) chk("b2_first_dark", an, 8'hFF);
      if (i == 12) chk("b2_dark_sev", sev_out, 7'h7F);
    end
    chk("b2_low_cycles", lows, 12);
    bright = 3'd7;

    // Mid-frame input change must not disturb the current frame.
    adv_to(296);
    data     = 32'hFFFFFFFF;
    digit_en = 8'h0F;
    dp_in    = 8'h01;
    adv_to(352);
    chk("mid_an", an, 8'hF7);
    chk("mid_sev_old", sev_out, hex_seg(4'h5));
    chk("mid_dp", dp_out, 1'b1);
    adv_to(512);
    chk("f2_fs", frame_start, 1'b1);
    chk("f2_sev_new", sev_out, hex_seg(4'hF));
    chk("f2_dp_lit", dp_out, 1'b0);

    // Disabled digits 4..7 stay dark, cadence unchanged.
    adv_to(640);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      if (an != 8'hFF || sev_out != 7'h7F) bad++;
    end
    chk("dis_slot4_dark", bad, 0);
    adv_to(767);
    chk("dis_pre_fs", frame_start, 1'b0);
    tick();
    chk("dis_cadence_fs", frame_start, 1'b1);

    // Reset at slot 5, phase 3; new inputs captured on release.
    adv_to(768 + 160 + 12);
    chk("pre_rst_an", an, 8'hFF);
    Rst      = 1'b1;
    data     = 32'h00000A05;
    digit_en = 8'hFF;
    dp_in    = 8'h20;
    tick();
    chk("abort_an", an, 8'hFF);
    chk("abort_sev", sev_out, 7'h7F);
    chk("abort_dp", dp_out, 1'b1);
    chk("abort_fs", frame_start, 1'b0);
    Rst = 1'b0;
    tick();
    chk("rerel_fs", frame_start, 1'b0);
    tick();
    t = 0;
    chk("restart_fs", frame_start, 1'b1);
    chk("restart_an", an, 8'hFE);
    chk("restart_sev", sev_out, hex_seg(4'h5));
    adv_to(32);
    chk("z_d1", sev_out, hex_seg(4'h0));
    adv_to(64);
    chk("z_d2", sev_out, hex_seg(4'hA));
    adv_to(128);
    chk("z_d4_an", an, 8'hEF);
    chk("z_d4", sev_out, hex_seg(4'h0));
    adv_to(160);
    chk("z_d5_an", an, 8'hDF);
    chk("z_d5", sev_out, hex_seg(4'h0));
    chk("z_d5_dp", dp_out, 1'b0);
    adv_to(192);
`ifdef SEVSEG_LZB_EN
    chk("lzb_d6_an", an, 8'hFF);
    chk("lzb_d6_sev", sev_out, 7'h7F);
    adv_to(224);
    chk("lzb_d7_an", an, 8'hFF);
    chk("lzb_d7_sev", sev_out, 7'h7F);
`else
    chk("nolzb_d6_an", an, 8'hBF);
    chk("nolzb_d6_sev", sev_out, hex_seg(4'h0));
    adv_to(224);
    chk("nolzb_d7_an", an, 8'h7F);
    chk("nolzb_d7_sev", sev_out, hex_seg(4'h0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
